servo_duty_ctrl: RTL and testbench

//  Upstream stage of the PWM generator in the remote-servo path.
//  - Accepts angle commands (0..ANGLE_MAX deg) over a valid/ready handshake.
//  - Converts each angle to a pulse width in clocks.
//  - Slews the pulse width toward the target by at most STEP_CLKS per servo frame.
//  - Drives the PWM's duty_cycle/period inputs, updating only on frame boundaries.

---
 rtl/servo_pkg.sv | 25 ++
 rtl/servo_div.sv | 68 ++++++
 rtl/servo_duty_ctrl.sv | 162 ++++++++++++++++
 tb/tb_servo_duty_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and parameter-derived constants for the servo duty controller.
//  - state_t        : command FSM states (IDLE -> MUL -> DIV -> IDLE)
//  - calc_period_clks: PWM frame length in system clocks
//  - calc_pulse_clks : pulse width in system clocks for a width in microseconds
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  function automatic logic [31:0] calc_period_clks(input int unsigned clk_freq,
                                                   input int unsigned servo_freq);
    return 32'(clk_freq / servo_freq);
  endfunction

  // Clocks per microsecond is an integer division, so CLK_FREQ is expected to
  // be a whole number of MHz.
  function automatic logic [31:0] calc_pulse_clks(input int unsigned pulse_us,
                                                  input int unsigned clk_freq);
    return 32'(pulse_us * (clk_freq / 1_000_000));
  endfunction

endpackage

// File: rtl/servo_div.sv
// 40/32 sequential restoring divider with a fixed 32-cycle latency.
//  i_clk, i_rst_n : clock, synchronous active-low reset (aborts a divide)
//  i_start        : load dividend/divisor, begin dividing
//  i_dividend     : 40-bit unsigned dividend, sampled on the start edge
//  i_divisor      : 32-bit unsigned divisor, must stay stable while busy
//  o_done         : high during the cycle whose rising edge completes the divide
//  o_quotient     : final quotient, valid while o_done is high
// The quotient must fit in 32 bits, which means dividend[39:32] < divisor; the
// upper 8 bits therefore seed the partial remainder and only the low 32 bits
// are shifted in, one per cycle.
module servo_div (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [39:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient
);

  logic [31:0] r_rem;
  logic [31:0] r_dvd;
  logic [31:0] r_quot;
  logic [4:0]  r_cnt;
  logic        r_busy;

  logic [32:0] w_shift;
  logic        w_qbit;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;

  always_comb begin
    w_shift    = {r_rem, r_dvd[31]};
    w_qbit     = (w_shift >= {1'b0, i_divisor});
    w_rem_nxt  = w_qbit ? 32'(w_shift - {1'b0, i_divisor}) : w_shift[31:0];
    w_quot_nxt = {r_quot[30:0], w_qbit};
  end

  // Completion is reported combinationally on the last iteration so the
  // caller can capture the quotient on that same edge.
  assign o_done     = r_busy && (r_cnt == 5'd31);
  assign o_quotient = w_quot_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= {24'd0, i_dividend[39:32]};
      r_dvd  <= i_dividend[31:0];
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_dvd  <= {r_dvd[30:0], 1'b0};
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/servo_duty_ctrl.sv
// Servo duty controller: converts angle commands to PWM pulse widths, slews
// the width toward the target once per frame, and feeds the PWM generator.
//  i_clk, i_rst_n  : clock, synchronous active-low reset
//  i_cmd_valid     : angle command present
//  i_cmd_angle     : requested angle, unsigned degrees
//  o_cmd_ready     : idle, can accept a command
//  o_cmd_clamped   : 1-cycle pulse, accepted angle was above ANGLE_MAX
//  o_duty_cycle    : pulse high time in clocks
//  o_period        : frame length in clocks
//  o_at_target     : armed and duty equals target
//  o_dbg_state     : current command FSM state
// Handshake: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both high; o_cmd_ready depends only on state, never on
// i_cmd_valid, and commands presented while busy are simply not taken.
module servo_duty_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned SERVO_FREQ   = 50,
  parameter int unsigned MIN_PULSE_US = 1000,
  parameter int unsigned MAX_PULSE_US = 2000,
  parameter int unsigned ANGLE_MAX    = 180,
  parameter int unsigned STEP_CLKS    = 2500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  input  logic [7:0]  i_cmd_angle,
  output logic        o_cmd_ready,
  output logic        o_cmd_clamped,
  output logic [31:0] o_duty_cycle,
  output logic [31:0] o_period,
  output logic        o_at_target,
  output state_t      o_dbg_state
);

  localparam logic [31:0] PERIOD_CLKS = calc_period_clks(CLK_FREQ, SERVO_FREQ);
  localparam logic [31:0] MIN_CLKS    = calc_pulse_clks(MIN_PULSE_US, CLK_FREQ);
  localparam logic [31:0] MAX_CLKS    = calc_pulse_clks(MAX_PULSE_US, CLK_FREQ);
  localparam logic [31:0] SPAN_CLKS   = MAX_CLKS - MIN_CLKS;
  localparam logic [31:0] STEP        = 32'(STEP_CLKS);
  localparam logic [31:0] AMAX        = 32'(ANGLE_MAX);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_frame_cnt;
  logic [7:0]  r_angle;
  logic        r_clamped;
  logic [31:0] r_duty;
  logic [31:0] r_target;
  logic        r_tgt_valid;
  logic        r_armed;
  logic [31:0] r_period;

  logic        w_accept;
  logic        w_div_start;
  logic        w_div_done;
  logic [31:0] w_div_quot;
  logic        w_angle_over;
  logic [7:0]  w_angle_sat;
  logic [39:0] w_num;
  logic        w_boundary;
  logic        w_up;
  logic [31:0] w_dist;
  logic [31:0] w_step;
  logic [31:0] w_duty_slewed;

  assign w_angle_over = (32'(i_cmd_angle) > AMAX);
  assign w_angle_sat  = w_angle_over ? 8'(ANGLE_MAX) : i_cmd_angle;

  // The product is formed during MUL and captured by the divider on the MUL
  // edge, so MUL costs exactly one cycle.
  assign w_num = 40'(r_angle) * 40'(SPAN_CLKS);

  servo_div u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_num),
    .i_divisor  (AMAX),
    .o_done     (w_div_done),
    .o_quotient (w_div_quot)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        w_div_start = 1'b1;
        w_state_nxt = ST_DIV;
      end
      ST_DIV: begin
        if (w_div_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One slew step toward the target; STEP of zero means jump directly.
  always_comb begin
    w_up          = (r_target > r_duty);
    w_dist        = w_up ? (r_target - r_duty) : (r_duty - r_target);
    w_step        = ((STEP == 32'd0) || (w_dist < STEP)) ? w_dist : STEP;
    w_duty_slewed = w_up ? (r_duty + w_step) : (r_duty - w_step);
  end

  assign w_boundary = (r_frame_cnt == PERIOD_CLKS - 32'd1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_angle     <= '0;
      r_clamped   <= 1'b0;
      r_duty      <= '0;
      r_target    <= '0;
      r_tgt_valid <= 1'b0;
      r_armed     <= 1'b0;
      r_period    <= PERIOD_CLKS;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_boundary ? 32'd0 : r_frame_cnt + 32'd1;
      r_clamped   <= w_accept && w_angle_over;
      r_period    <= PERIOD_CLKS;
      if (w_accept) begin
        r_angle <= w_angle_sat;
      end
      if (w_div_done) begin
        r_target    <= MIN_CLKS + w_div_quot;
        r_tgt_valid <= 1'b1;
      end
      // Reads the pre-edge target, so a target written on a boundary edge
      // only takes effect at the following boundary.
      if (w_boundary) begin
        if (!r_armed && r_tgt_valid) begin
          r_duty  <= r_target;
          r_armed <= 1'b1;
        end else if (r_armed) begin
          r_duty <= w_duty_slewed;
        end
      end
    end
  end

  assign o_cmd_ready   = (r_state == ST_IDLE);
  assign o_cmd_clamped = r_clamped;
  assign o_duty_cycle  = r_duty;
  assign o_period      = r_period;
  assign o_at_target   = r_armed && (r_duty == r_target);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_servo_duty_ctrl.sv
// Testbench for servo_duty_ctrl. A reference model tracks frame position,
// command latency and the per-frame duty rule; targets are pushed on accept
// and popped when the command completes; the monitor compares every cycle.
module tb_servo_duty_ctrl;
  import servo_pkg::*;

  localparam int unsigned CLK_FREQ   = 1_000_000;
  localparam int unsigned SERVO_FREQ = 1000;
  localparam int unsigned MIN_US     = 1000;
  localparam int unsigned MAX_US     = 2000;
  localparam int unsigned AMAX       = 180;
  localparam int unsigned STEP       = 100;
  localparam int unsigned PERIOD     = 1000;   // CLK_FREQ/SERVO_FREQ
  localparam int unsigned MINC       = 1000;   // MIN_US * 1 clock/us
  localparam int unsigned MAXC       = 2000;
  localparam int unsigned LAT        = 33;     // accept edge to target write

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_angle;
  logic        cmd_ready;
  logic        cmd_clamped;
  logic [31:0] duty_cycle;
  logic [31:0] period;
  logic        at_target;
  state_t      dbg_state;

  servo_duty_ctrl #(
    .CLK_FREQ     (CLK_FREQ),
    .SERVO_FREQ   (SERVO_FREQ),
    .MIN_PULSE_US (MIN_US),
    .MAX_PULSE_US (MAX_US),
    .ANGLE_MAX    (AMAX),
    .STEP_CLKS    (STEP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .i_cmd_angle   (cmd_angle),
    .o_cmd_ready   (cmd_ready),
    .o_cmd_clamped (cmd_clamped),
    .o_duty_cycle  (duty_cycle),
    .o_period      (period),
    .o_at_target   (at_target),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] exp_q[$];
  int unsigned m_pos, m_duty, m_target, m_busy;
  bit          m_tvalid, m_armed, m_clamped;

  always @(posedge clk) begin
    bit          bnd, wr;
    int unsigned a, new_t, d;
    wr = 0;
    new_t = 0;
    if (!rst_n) begin
      m_pos = 0; m_duty = 0; m_target = 0; m_busy = 0;
      m_tvalid = 0; m_armed = 0; m_clamped = 0;
      exp_q.delete();
    end else begin
      bnd = (m_pos == PERIOD - 1);
      m_pos = bnd ? 0 : m_pos + 1;
      m_clamped = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0 && exp_q.size() > 0) begin
          wr = 1;
          new_t = exp_q.pop_front();
        end
      end else if (cmd_valid) begin
        a = (cmd_angle > AMAX) ? AMAX : cmd_angle;
        m_clamped = (cmd_angle > AMAX);
        exp_q.push_back(32'(MINC + (a * (MAXC - MINC)) / AMAX));
        m_busy = LAT;
      end
      if (bnd) begin
        if (!m_armed && m_tvalid) begin
          m_duty = m_target;
          m_armed = 1;
        end else if (m_armed) begin
          d = (m_target > m_duty) ? m_target - m_duty : m_duty - m_target;
          if (d > STEP) d = STEP;
          m_duty = (m_target > m_duty) ? m_duty + d : m_duty - d;
        end
      end
      if (wr) begin
        m_target = new_t;
        m_tvalid = 1;
      end
    end
    #1;
    check("duty_cycle", duty_cycle, 32'(m_duty));
    check("at_target", {31'd0, at_target}, {31'd0, m_armed && (m_duty == m_target)});
    check("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_busy == 0});
    check("cmd_clamped", {31'd0, cmd_clamped}, {31'd0, m_clamped});
    check("period", period, 32'(PERIOD));
  end

  // ---------------- driver tasks ----------------
  task automatic accept_wait(output bit ok);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout at %0t: cmd_ready never seen high, required within 200 cycles", $time);
    end
  endtask

  task automatic send(input logic [7:0] ang);
    bit ok;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = ang;
    accept_wait(ok);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Valid stays high across both commands; the second angle is presented
  // while the first is still being processed.
  task automatic hold_two(input logic [7:0] a1, input logic [7:0] a2);
    bit ok;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_angle = a1;
    accept_wait(ok);
    @(negedge clk);
    cmd_angle = a2;
    accept_wait(ok);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_angle = 8'd0;
    idle(3);
    rst_n = 1'b1;
    idle(20);

    send(8'd90);                 // direct load to 1500
    idle(2 * PERIOD);
    send(8'd180);                // slew 1500 -> 2000 in 100-clock steps
    idle(6 * PERIOD);
    send(8'd200);                // clamped to 180
    idle(PERIOD);
    send(8'd0);                  // target 1000
    idle(40);
    send(8'd1);                  // target 1005, truncated
    idle(12 * PERIOD);
    hold_two(8'd45, 8'd135);
    idle(6 * PERIOD);

    for (int i = 0; i < 10; i++) begin
      send(8'($urandom_range(0, 255)));
      idle($urandom_range(0, 1500));
    end

    send(8'd100);                // reset in the middle of the divide
    idle(10);
    pulse_reset();
    send(8'd60);                 // direct load after reset
    idle(2 * PERIOD);
    send(8'd180);                // reset while slewing
    idle(2 * PERIOD + 300);
    pulse_reset();
    send(8'd20);
    idle(2 * PERIOD + 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
